// File: rtl/seven_segment_scan_controller.sv
// Multiplexed 7-segment score display driver.
// Sequential double-dabble BCD converter feeding a blanking/blinking digit scanner.
module seven_segment_scan_controller #(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_W       = 14,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLINK_TICKS   = 500,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  value_valid,
    output logic                  busy,
    input  logic                  blink_en,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] Anode_Activate,
    output logic [6:0]            LED_out
);

    localparam int RAW_DIGITS = (VALUE_W * 3) / 10 + 1;
    localparam int SCR_DIGITS = (RAW_DIGITS > NUM_DIGITS) ? RAW_DIGITS : NUM_DIGITS;
    localparam int SCR_W      = 4 * SCR_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(VALUE_W + 1);
    localparam int SLOT_W     = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    conv_state_t           state;
    logic [VALUE_W-1:0]    bin_q;
    logic [SCR_W-1:0]      bcd_q;
    logic [SCR_W-1:0]      bcd_adj;
    logic [SCR_W-1:0]      bcd_next;
    logic [CNT_W-1:0]      shift_cnt;
    logic [DISP_W-1:0]     disp_q;
    logic [DISP_W-1:0]     disp_c;
    logic                  ovf_c;

    logic [SLOT_W-1:0]     slot;
    logic [IDX_W-1:0]      idx;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  phase_off;
    logic                  tick;
    logic [3:0]            digit;
    logic                  upper_nz;
    logic                  blanked;
    logic [6:0]            seg_c;
    logic [NUM_DIGITS-1:0] anode_c;
    logic [6:0]            led_c;

    // Add-3 on every BCD digit >= 5, then shift in the next binary bit
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < SCR_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[SCR_W-2:0], bin_q[VALUE_W-1]};
    end

    // Saturate to all nines when a digit beyond the display is non-zero
    always_comb begin
        ovf_c = 1'b0;
        for (int i = NUM_DIGITS; i < SCR_DIGITS; i++) begin
            ovf_c = ovf_c | (|bcd_q[4*i +: 4]);
        end
        disp_c = ovf_c ? {NUM_DIGITS{4'd9}} : bcd_q[DISP_W-1:0];
    end

    // Converter FSM; busy drops one cycle after the commit
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            shift_cnt <= '0;
            disp_q    <= '0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (value_valid && !busy) begin
                        bin_q     <= value_in;
                        bcd_q     <= '0;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    bin_q     <= bin_q << 1;
                    bcd_q     <= bcd_next;
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == CNT_W'(VALUE_W - 1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_q   <= disp_c;
                    overflow <= ovf_c;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tick = (slot == SLOT_W'(REFRESH_DIV - 1));

    // Select current digit and decide whether it is a blanked leading zero
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx) && disp_q[4*j +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        digit   = disp_q[4*idx +: 4];
        blanked = (BLANK_LEADING != 0) && (idx != '0) && !upper_nz;
    end

    // Active-low segment decoder, non-BCD codes dark
    always_comb begin
        case (digit)
            4'd0:    seg_c = 7'b0000001;
            4'd1:    seg_c = 7'b1001111;
            4'd2:    seg_c = 7'b0010010;
            4'd3:    seg_c = 7'b0000110;
            4'd4:    seg_c = 7'b1001100;
            4'd5:    seg_c = 7'b0100100;
            4'd6:    seg_c = 7'b0100000;
            4'd7:    seg_c = 7'b0001111;
            4'd8:    seg_c = 7'b0000000;
            4'd9:    seg_c = 7'b0000100;
            default: seg_c = 7'b1111111;
        endcase
    end

    // Anode/cathode pattern for the digit about to be latched
    always_comb begin
        anode_c = ~(NUM_DIGITS'(1) << idx);
        led_c   = seg_c;
        if (blanked) begin
            anode_c = '1;
            led_c   = 7'b1111111;
        end
        if (blink_en && phase_off) begin
            anode_c = '1;
        end
    end

    // Slot timer, digit scan, blink phase and registered pin drivers
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            slot           <= '0;
            idx            <= '0;
            blink_cnt      <= '0;
            phase_off      <= 1'b0;
            Anode_Activate <= '1;
            LED_out        <= 7'b1111111;
        end else if (tick) begin
            slot           <= '0;
            Anode_Activate <= anode_c;
            LED_out        <= led_c;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
            if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                phase_off <= ~phase_off;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            slot <= slot + 1'b1;
        end
    end

endmodule
